bc_polinomio: RTL and testbench
===============================

// Module: bc_polinomio
// PURPOSE
//  Control block (FSM) paired with the polynomial datapath BO. Drives its mux selects,
//  register loads and ULA op to evaluate resultado = a*x*x + b*x + c (mod 2^16).
//  Sits directly upstream of BO; BO's resultado is valid when pronto pulses.
//  Start/done handshake: inicio in, pronto/ocupado out.
// PARAMETERS
//  H_SOMA   1'b0  value of h that selects ULA addition
//  H_MULT   1'b1  value of h that selects ULA multiplication (low 16 bits kept)
// PORTS
//  clk      in   1  single clock, rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  inicio   in   1  start request; sampled only in IDLE
//  m0       out  2  BO mu_0 select: 0=const 0, 1=a, 2=b, 3=c
//  m1       out  2  BO mu_1 select (ULA B): 0=mu_0, 1=X, 2=S, 3=H
//  m2       out  2  BO mu_2 select (ULA A): 0=X, 1=mu_0, 2=S, 3=H
//  lx       out  1  load X register
//  ls       out  1  load S register (S = resultado)
//  lh       out  1  load H register
//  h        out  1  ULA op (H_SOMA/H_MULT)
//  ocupado  out  1  high in every state except IDLE
//  pronto   out  1  one-cycle pulse; BO resultado is valid in that cycle
//  n_calc   out  8  completed-evaluation count (only with BC_CONTA_EN)
// BEHAVIOUR
//  - Moore FSM, 3-bit state reg; all outputs decoded from state only.
//  - Reset (rst_n=0, async): state=IDLE; m0=m1=m2=0, lx=ls=lh=0, h=H_SOMA,
//    ocupado=0, pronto=0, n_calc=0. Mid-computation reset aborts immediately;
//    no load strobe is asserted after rst_n falls.
//  - Per-state outputs (unlisted loads=0, unlisted selects=0):
//    IDLE    : none.              inicio=1 -> LOAD_X, else stay.
//    LOAD_X  : lx=1.                                   -> MUL_AX
//    MUL_AX  : m0=1,m2=1,m1=1,h=MULT,lh=1 (H=a*X)      -> MUL_AXX
//    MUL_AXX : m2=3,m1=1,h=MULT,lh=1     (H=H*X)       -> MUL_BX
//    MUL_BX  : m0=2,m2=1,m1=1,h=MULT,ls=1 (S=b*X)      -> ADD_H
//    ADD_H   : m2=2,m1=3,h=SOMA,ls=1     (S=S+H)       -> ADD_C
//    ADD_C   : m0=3,m1=0,m2=2,h=SOMA,ls=1 (S=S+c)      -> DONE
//    DONE    : pronto=1.                               -> IDLE (unconditional)
//  - Latency: inicio sampled high at edge k -> pronto high in cycle after edge k+6.
//    Min issue interval 8 cycles (inicio held high -> back-to-back evaluations).
//  - inicio ignored outside IDLE; a, b, c must stay stable LOAD_X..ADD_C; x only
//    needs to be valid in LOAD_X.
//  - Arithmetic is BO's: 16-bit, wrap mod 2^16, no overflow flag.
//  - Exactly one of lx/ls/lh high per active state; never two at once.
// CONFIGURATION
//  - BC_CONTA_EN defined: n_calc increments by 1 on each DONE cycle, wraps
//    255->0, cleared by rst_n.
//  - BC_CONTA_EN undefined: n_calc port tied to 8'd0, no counter flops.
//  - FSM sequence and timing identical in both builds.
// TESTING (bench: bc_polinomio + BO)
//  - a=2,b=3,c=4,x=5, pulse inicio -> pronto 7 cycles after inicio sampled,
//    resultado=69; ocupado high for 7 cycles.
//  - a=1,b=0,c=0,x=256 -> resultado=0 (x*x wraps); a=0,b=0,c=7,x=9 -> 7.
//  - Walk states, compare {m0,m1,m2,lx,ls,lh,h} per state vs table; assert
//    one-hot-or-zero loads every cycle.
//  - Hold inicio=1 for 3 evaluations (x=1,2,3; a=b=c=1) -> pronto every 8 cycles,
//    resultado 3,7,13.
//  - rst_n low during MUL_BX -> outputs 0 at once, IDLE; next evaluation correct.
//  - BC_CONTA_EN: 257 evaluations -> n_calc=1; without macro n_calc stays 0.

Source files
------------

// File: rtl/bc_polinomio.sv
// Control FSM for the polynomial datapath BO: sequences resultado = a*x*x + b*x + c.
// Optional completed-evaluation counter on n_calc enabled by defining BC_CONTA_EN.
module bc_polinomio #(
    parameter logic H_SOMA = 1'b0,
    parameter logic H_MULT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       lx,
    output logic       ls,
    output logic       lh,
    output logic       h,
    output logic       ocupado,
    output logic       pronto,
    output logic [7:0] n_calc
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        MUL_AX,
        MUL_AXX,
        MUL_BX,
        ADD_H,
        ADD_C,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Control word layout: {m0, m1, m2, lx, ls, lh, h, ocupado, pronto}
    logic [11:0] ctrl;

    function automatic logic [11:0] decode(input state_t s);
        logic [1:0] d_m0, d_m1, d_m2;
        logic       d_lx, d_ls, d_lh, d_h, d_oc, d_pr;
        d_m0 = 2'd0;
        d_m1 = 2'd0;
        d_m2 = 2'd0;
        d_lx = 1'b0;
        d_ls = 1'b0;
        d_lh = 1'b0;
        d_h  = H_SOMA;
        d_oc = 1'b1;
        d_pr = 1'b0;
        case (s)
            IDLE:    d_oc = 1'b0;
            LOAD_X:  d_lx = 1'b1;
            MUL_AX:  begin d_m0 = 2'd1; d_m2 = 2'd1; d_m1 = 2'd1; d_h = H_MULT; d_lh = 1'b1; end
            MUL_AXX: begin d_m2 = 2'd3; d_m1 = 2'd1; d_h = H_MULT; d_lh = 1'b1; end
            MUL_BX:  begin d_m0 = 2'd2; d_m2 = 2'd1; d_m1 = 2'd1; d_h = H_MULT; d_ls = 1'b1; end
            ADD_H:   begin d_m2 = 2'd2; d_m1 = 2'd3; d_ls = 1'b1; end
            ADD_C:   begin d_m0 = 2'd3; d_m2 = 2'd2; d_ls = 1'b1; end
            DONE:    d_pr = 1'b1;
            default: d_oc = 1'b0;
        endcase
        return {d_m0, d_m1, d_m2, d_lx, d_ls, d_lh, d_h, d_oc, d_pr};
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inicio) state_next = LOAD_X;
            LOAD_X:  state_next = MUL_AX;
            MUL_AX:  state_next = MUL_AXX;
            MUL_AXX: state_next = MUL_BX;
            MUL_BX:  state_next = ADD_H;
            ADD_H:   state_next = ADD_C;
            ADD_C:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ctrl  <= {6'd0, 3'd0, H_SOMA, 2'd0};
        end else begin
            state <= state_next;
            ctrl  <= decode(state_next);
        end
    end

    assign {m0, m1, m2, lx, ls, lh, h, ocupado, pronto} = ctrl;

`ifdef BC_CONTA_EN
    logic [7:0] conta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conta <= 8'd0;
        end else if (state == DONE) begin
            conta <= conta + 8'd1;
        end
    end

    assign n_calc = conta;
`else
    assign n_calc = 8'd0;
`endif

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio driving a behavioural BO datapath; results are checked
// against a direct evaluation of a*x*x + b*x + c mod 2^16.
module tb_bc_polinomio;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic [1:0]  m0, m1, m2;
    logic        lx, ls, lh, h, ocupado, pronto;
    logic [7:0]  n_calc;

    logic [15:0] a, b, c, x;
    logic [15:0] reg_x, reg_s, reg_h, mu0, ula_a, ula_b, ula;

    int n_cmp = 0;
    int n_bad = 0;
    int evals = 0;

    always #5 clk = ~clk;

    bc_polinomio dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .m0      (m0),
        .m1      (m1),
        .m2      (m2),
        .lx      (lx),
        .ls      (ls),
        .lh      (lh),
        .h       (h),
        .ocupado (ocupado),
        .pronto  (pronto),
        .n_calc  (n_calc)
    );

    // Behavioural BO: three registers around a two-input ULA.
    always_comb begin
        case (m0)
            2'd0:    mu0 = 16'd0;
            2'd1:    mu0 = a;
            2'd2:    mu0 = b;
            default: mu0 = c;
        endcase
        case (m1)
            2'd0:    ula_b = mu0;
            2'd1:    ula_b = reg_x;
            2'd2:    ula_b = reg_s;
            default: ula_b = reg_h;
        endcase
        case (m2)
            2'd0:    ula_a = reg_x;
            2'd1:    ula_a = mu0;
            2'd2:    ula_a = reg_s;
            default: ula_a = reg_h;
        endcase
        ula = h ? 16'(ula_a * ula_b) : 16'(ula_a + ula_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_x <= 16'd0;
            reg_s <= 16'd0;
            reg_h <= 16'd0;
        end else begin
            if (lx) reg_x <= x;
            if (ls) reg_s <= ula;
            if (lh) reg_h <= ula;
        end
    end

    // Expected control word per cycle, {m0,m1,m2,lx,ls,lh,h,ocupado,pronto}
    logic [11:0] ctrl_v;
    assign ctrl_v = {m0, m1, m2, lx, ls, lh, h, ocupado, pronto};

    localparam logic [11:0] IDLE_V = 12'b00_00_00_0000_00;
    logic [11:0] tbl [7] = '{
        12'b00_00_00_1000_10,
        12'b01_01_01_0011_10,
        12'b00_01_11_0011_10,
        12'b10_01_01_0101_10,
        12'b00_11_10_0100_10,
        12'b11_00_10_0100_10,
        12'b00_00_00_0000_11
    };

    function automatic logic [15:0] ref_res(input logic [15:0] ra, rb, rc, rx);
        longint unsigned t;
        t = 64'(ra) * 64'(rx) * 64'(rx) + 64'(rb) * 64'(rx) + 64'(rc);
        return t[15:0];
    endfunction

    function automatic logic [7:0] exp_n();
`ifdef BC_CONTA_EN
        return 8'(evals % 256);
`else
        return 8'd0;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Loads must be one-hot-or-zero in every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1)
            check_output("loads_onehot0", 32'($onehot0({lx, ls, lh})), 32'd1);
    end

    // Entered at the LOAD_X negedge; ends at the DONE negedge.
    task automatic walk(input logic [15:0] exp_res);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 2) x = 16'($urandom);
            check_output($sformatf("state%0d_ctrl", i), 32'(ctrl_v), 32'(tbl[i]));
        end
        check_output("resultado", 32'(reg_s), 32'(exp_res));
        evals++;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_ctrl"}, 32'(ctrl_v), 32'(IDLE_V));
        check_output({tag, "_n_calc"}, 32'(n_calc), 32'(exp_n()));
    endtask

    task automatic apply_stimulus(input logic [15:0] va, vb, vc, vx);
        logic [15:0] exp_res;
        exp_res = ref_res(va, vb, vc, vx);
        @(negedge clk);
        a = va; b = vb; c = vc; x = vx;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        walk(exp_res);
        @(negedge clk);
        check_idle("idle");
    endtask

    initial begin
        rst_n  = 1'b0;
        inicio = 1'b0;
        a = 16'd0; b = 16'd0; c = 16'd0; x = 16'd0;
        repeat (2) @(negedge clk);
        check_output("reset_ctrl", 32'(ctrl_v), 32'(IDLE_V));
        check_output("reset_n_calc", 32'(n_calc), 32'd0);
        rst_n = 1'b1;

        apply_stimulus(16'd2, 16'd3, 16'd4, 16'd5);
        apply_stimulus(16'd1, 16'd0, 16'd0, 16'd256);
        apply_stimulus(16'd0, 16'd0, 16'd7, 16'd9);

        // Back-to-back evaluations with inicio held high.
        @(negedge clk);
        a = 16'd1; b = 16'd1; c = 16'd1; x = 16'd1;
        inicio = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) inicio = 1'b0;
            walk(16'(k * k + k + 1));
            x = 16'(k + 1);
            @(negedge clk);
            check_idle("hold_idle");
        end

        // Abort in MUL_BX with an asynchronous reset.
        @(negedge clk);
        a = 16'd9; b = 16'd8; c = 16'd7; x = 16'd6;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        check_output("pre_abort_ctrl", 32'(ctrl_v), 32'(tbl[3]));
        rst_n = 1'b0;
        #1;
        check_output("abort_ctrl", 32'(ctrl_v), 32'(IDLE_V));
        check_output("abort_n_calc", 32'(n_calc), 32'd0);
        evals = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // 257 random evaluations after the reset; counter ends at 1 when enabled.
        for (int n = 0; n < 257; n++) begin
            apply_stimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
